motor_drive_ctrl: RTL

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

---
 rtl/motor_drive_ctrl_if.sv | 22 ++
 rtl/motor_drive_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/motor_drive_ctrl_if.sv
// Bundle of the motor_drive_ctrl drive-side signals.
// master drives enable/divider/command; slave returns duties and status.
interface motor_drive_ctrl_if;
  logic        enable;
  logic [31:0] tick_div;
  logic [31:0] cmd_in;
  logic        cmd_valid;
  logic [31:0] ch0_duty;
  logic [31:0] ch1_duty;
  logic [1:0]  state;
  logic        busy;

  modport master (
    output enable, tick_div, cmd_in, cmd_valid,
    input  ch0_duty, ch1_duty, state, busy
  );

  modport slave (
    input  enable, tick_div, cmd_in, cmd_valid,
    output ch0_duty, ch1_duty, state, busy
  );
endinterface

// File: rtl/motor_drive_ctrl.sv
// H-bridge drive controller: signed command -> FWD/REV duty with dead time.
// Ports: CLK, RST_n (async low), ENABLE, TICK_DIV, CMD_IN, CMD_VALID in;
// CH0_DUTY, CH1_DUTY, STATE, BUSY out. Macro MOTOR_DRIVE_SLEW_LIMIT_EN
// enables per-tick slew limiting of the applied duty.
module motor_drive_ctrl #(
  parameter int unsigned DUTY_MAX  = 9999,
  parameter int unsigned DUTY_MIN  = 1,
  parameter int unsigned CMD_SHIFT = 15,
  parameter int unsigned DEAD_CYC  = 1000,
  parameter int unsigned SLEW_STEP = 16
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        ENABLE,
  input  logic [31:0] TICK_DIV,
  input  logic [31:0] CMD_IN,
  input  logic        CMD_VALID,
  output logic [31:0] CH0_DUTY,
  output logic [31:0] CH1_DUTY,
  output logic [1:0]  STATE,
  output logic        BUSY
);

`ifdef MOTOR_DRIVE_SLEW_LIMIT_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam logic [31:0] DMAX  = 32'(DUTY_MAX);
  localparam logic [31:0] DMIN  = 32'(DUTY_MIN);
  localparam logic [31:0] SSTEP = 32'(SLEW_STEP);
  localparam logic [31:0] DLAST = 32'(DEAD_CYC - 1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_FWD  = 2'd1,
    ST_DEAD = 2'd2,
    ST_REV  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] tgt_q;
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] dcnt_q, dcnt_d;
  logic [31:0] app_q, app_d;
  logic [31:0] ch0_q, ch0_d;
  logic [31:0] ch1_q, ch1_d;

  logic [31:0] abs_w, shr_w, tmag_w;
  logic        t_neg, t_zero, t_pos;
  logic [31:0] div_m1;
  logic        tick_w;
  logic [32:0] up_w, dn_w;
  logic [31:0] slew_w, step_w, clamp_w;

  // Two's-complement magnitude; -2^31 becomes 2^31 unsigned.
  assign abs_w  = tgt_q[31] ? (~tgt_q + 32'd1) : tgt_q;
  assign shr_w  = abs_w >> CMD_SHIFT;
  assign tmag_w = (shr_w > DMAX) ? DMAX : shr_w;
  assign t_neg  = tgt_q[31];
  assign t_zero = (tgt_q == 32'd0);
  assign t_pos  = !t_neg && !t_zero;

  // >= so a divider lowered below the count fires at once.
  assign div_m1 = (TICK_DIV == 32'd0) ? 32'd0 : TICK_DIV - 32'd1;
  assign tick_w = (tcnt_q >= div_m1);
  assign tcnt_d = tick_w ? 32'd0 : tcnt_q + 32'd1;

  // 33-bit sums so the step test cannot wrap.
  assign up_w = {1'b0, app_q} + {1'b0, SSTEP};
  assign dn_w = {1'b0, tmag_w} + {1'b0, SSTEP};

  always_comb begin
    slew_w = tmag_w;
    if (app_q < tmag_w) begin
      if (up_w < {1'b0, tmag_w}) slew_w = up_w[31:0];
    end else begin
      if (dn_w < {1'b0, app_q}) slew_w = app_q - SSTEP;
    end
  end

  assign step_w = SLEW_EN ? slew_w : tmag_w;

  always_comb begin
    state_d = state_q;
    app_d   = app_q;
    dcnt_d  = dcnt_q;
    if (!ENABLE) begin
      state_d = ST_STOP;
      app_d   = 32'd0;
      dcnt_d  = 32'd0;
    end else begin
      unique case (state_q)
        ST_STOP: begin
          if (tick_w && t_pos) begin
            state_d = ST_FWD;
            app_d   = DMIN;
          end else if (tick_w && t_neg) begin
            state_d = ST_REV;
            app_d   = DMIN;
          end
        end
        ST_FWD, ST_REV: begin
          if (tick_w) begin
            if (t_zero) begin
              state_d = ST_STOP;
            end else if ((state_q == ST_FWD) == t_neg) begin
              state_d = ST_DEAD;
              dcnt_d  = 32'd0;
            end else begin
              app_d = step_w;
            end
          end
        end
        ST_DEAD: begin
          if (dcnt_q >= DLAST) begin
            dcnt_d  = 32'd0;
            app_d   = DMIN;
            state_d = t_zero ? ST_STOP :
                      t_neg  ? ST_REV  : ST_FWD;
          end else begin
            dcnt_d = dcnt_q + 32'd1;
          end
        end
      endcase
    end
  end

  // Duties are built from next state so they land on the same edge.
  assign clamp_w = (app_d > DMAX) ? DMAX :
                   (app_d < DMIN) ? DMIN : app_d;
  assign ch0_d = (state_d == ST_FWD) ? clamp_w : DMIN;
  assign ch1_d = (state_d == ST_REV) ? clamp_w : DMIN;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_STOP;
      tgt_q   <= 32'd0;
      tcnt_q  <= 32'd0;
      dcnt_q  <= 32'd0;
      app_q   <= 32'd0;
      ch0_q   <= DMIN;
      ch1_q   <= DMIN;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      dcnt_q  <= dcnt_d;
      app_q   <= app_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      if (CMD_VALID) tgt_q <= CMD_IN;
    end
  end

  assign CH0_DUTY = ch0_q;
  assign CH1_DUTY = ch1_q;
  assign STATE    = state_q;
  assign BUSY     = (state_q == ST_DEAD);

endmodule
